sensor_error_sequencer: RTL and testbench

Controller that drives the 3-bit error code (A,B,C) into the digit-4 sensor-error seven-segment decoder of the coffee machine's CPLD display. Debounces five active-high sensor fault lines, latches faults until operator acknowledge, and sequences the display through all latched faults in round-robin order with a fixed dwell time. Runs a lamp-test pattern after reset and raises a brew inhibit while any fault is latched.

---
 rtl/sensor_error_pkg.sv | 50 +++++
 rtl/sensor_debounce.sv | 46 ++++
 rtl/sensor_error_sequencer.sv | 114 +++++++++++
 tb/tb_sensor_error_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sensor_error_pkg.sv
// Shared types and constants for the sensor-error display sequencer.
// Holds display codes, fault indices, FSM state encoding and the
// round-robin "next latched fault" search used by the sequencer.
package sensor_error_pkg;

  localparam int NUM_SENSORS = 5;

  typedef logic [2:0] code_t;
  typedef logic [2:0] fault_idx_t;
  typedef logic [NUM_SENSORS-1:0] fault_mask_t;

  // Decoder input patterns; 001..101 are fault index + 1, 110 is never driven
  localparam code_t CODE_OK   = 3'b000;
  localparam code_t CODE_TEST = 3'b111;

  // Bit positions of the individual sensor fault lines
  localparam fault_idx_t FAULT_NO_WATER  = 3'd0;
  localparam fault_idx_t FAULT_NO_COFFEE = 3'd1;
  localparam fault_idx_t FAULT_NO_SUGAR  = 3'd2;
  localparam fault_idx_t FAULT_NO_CUP    = 3'd3;
  localparam fault_idx_t FAULT_HEATER    = 3'd4;
  localparam fault_idx_t LAST_IDX        = FAULT_HEATER;

  typedef enum logic [1:0] {
    ST_TEST,
    ST_IDLE,
    ST_SHOW
  } state_t;

  // Nearest set bit strictly after cur, wrapping around; returns cur itself
  // when it is the only set bit, and cur unchanged when the mask is empty.
  // Starting from LAST_IDX yields the lowest set bit.
  function automatic fault_idx_t next_set(input fault_mask_t mask, input fault_idx_t cur);
    fault_idx_t res;
    logic [3:0] cand;
    res = cur;
    // Walk from farthest to nearest so the nearest hit is the one kept
    for (int i = NUM_SENSORS; i >= 1; i--) begin
      cand = {1'b0, cur} + 4'(i);
      if (cand >= 4'(NUM_SENSORS)) begin
        cand = cand - 4'(NUM_SENSORS);
      end
      if (mask[cand[2:0]]) begin
        res = cand[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor line: 2-flop synchronizer followed by a debounce filter.
// Latency: filtered follows a stable raw change after 2 + DEBOUNCE_CYCLES cycles.
// No backpressure; a disagreement shorter than DEBOUNCE_CYCLES restarts the count.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          synced;
  logic [CW-1:0] cnt;

  // Bring the asynchronous raw line into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

  // Count consecutive disagreeing cycles; flip the filtered value on the last one
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (synced == filtered) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      filtered <= synced;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_error_sequencer.sv
// Debounces five fault lines, latches them until ack, cycles the digit through them.
// Latency: raw rise to err_mask is 3 + DEBOUNCE_CYCLES cycles; code follows err_mask by 1.
// No backpressure; ack is level-sampled every cycle and only clears faults that have gone away.
module sensor_error_sequencer
  import sensor_error_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int TEST_CYCLES     = 25_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] sensor,
  input  logic                   ack,
  output logic [2:0]             code,
  output logic [NUM_SENSORS-1:0] err_mask,
  output logic                   err_any,
  output logic                   brew_inhibit
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int TW = $clog2(TEST_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] TEST_LAST  = TW'(TEST_CYCLES - 1);

  fault_mask_t   filtered;
  state_t        state, state_nxt;
  fault_idx_t    idx, idx_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [TW-1:0] test_cnt, test_nxt;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_deb
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw     (sensor[g]),
      .filtered(filtered[g])
    );
  end

  // Latch faults; a bit clears only on ack once its filtered line is low, so set always wins
  always_ff @(posedge clk) begin
    if (reset) begin
      err_mask <= '0;
    end else begin
      err_mask <= (err_mask & ~({NUM_SENSORS{ack}} & ~filtered)) | filtered;
    end
  end

  assign err_any      = |err_mask;
  assign brew_inhibit = (state == ST_TEST) || err_any;

  // Sequencer state, current fault index and the two cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_TEST;
      idx      <= '0;
      dwell    <= '0;
      test_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      dwell    <= dwell_nxt;
      test_cnt <= test_nxt;
    end
  end

  // Next-state, index advance and display code; dwell restarts on any state or index change
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell + 1'b1;
    test_nxt  = test_cnt;
    code      = CODE_OK;
    unique case (state)
      ST_TEST: begin
        code      = CODE_TEST;
        dwell_nxt = '0;
        test_nxt  = test_cnt + 1'b1;
        if (test_cnt == TEST_LAST) begin
          state_nxt = ST_IDLE;
          test_nxt  = '0;
        end
      end
      ST_IDLE: begin
        code      = CODE_OK;
        dwell_nxt = '0;
        if (err_any) begin
          state_nxt = ST_SHOW;
          idx_nxt   = next_set(err_mask, LAST_IDX);
        end
      end
      ST_SHOW: begin
        code = idx + 3'd1;
        if (!err_any) begin
          state_nxt = ST_IDLE;
          dwell_nxt = '0;
        end else if (!err_mask[idx] || (dwell == DWELL_LAST)) begin
          // Fault on display was acknowledged away, or its dwell expired
          idx_nxt   = next_set(err_mask, idx);
          dwell_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_TEST;
        dwell_nxt = '0;
        test_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sensor_error_sequencer.sv
// Directed bench for sensor_error_sequencer with a queue-based scoreboard.
// Expected values are pushed as each step is driven and popped at the sample point.
// Samples are taken on the falling edge; inputs change right after sampling.
module tb_sensor_error_sequencer;
  import sensor_error_pkg::*;

  localparam int DEB   = 4;
  localparam int DWELL = 10;
  localparam int TST   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sensor;
  logic       ack;
  logic [2:0] code;
  logic [4:0] err_mask;
  logic       err_any;
  logic       brew_inhibit;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sensor_error_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_CYCLES   (DWELL),
    .TEST_CYCLES    (TST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor      (sensor),
    .ack         (ack),
    .code        (code),
    .err_mask    (err_mask),
    .err_any     (err_any),
    .brew_inhibit(brew_inhibit)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int pos;
    reset  = 1'b1;
    sensor = 5'b0;
    ack    = 1'b0;
    tick();
    tick();

    // Reset state
    push(8'h7);  chk("rst_code", 8'(code));
    push(8'h0);  chk("rst_mask", 8'(err_mask));
    push(8'h0);  chk("rst_err_any", 8'(err_any));
    push(8'h1);  chk("rst_brew", 8'(brew_inhibit));

    // Lamp test for TST cycles, then OK pattern
    reset = 1'b0;
    for (int i = 0; i <= TST; i++) begin
      push((i < TST) ? 8'h7 : 8'h0);
      chk("lamp_code", 8'(code));
      if (i == 0)   begin push(8'h1); chk("lamp_brew_on", 8'(brew_inhibit)); end
      if (i == TST) begin push(8'h0); chk("lamp_brew_off", 8'(brew_inhibit)); end
      if (i < TST) tick();
    end

    // Single held fault: latch after 2 + DEB + 1 cycles, shown one cycle later
    sensor = 5'b00010;
    for (int i = 1; i <= DEB + 3; i++) begin
      tick();
      if (i == DEB + 2) begin push(8'h00); chk("latch_early_mask", 8'(err_mask)); end
    end
    push(8'h02); chk("latch_mask", 8'(err_mask));
    push(8'h1);  chk("latch_err_any", 8'(err_any));
    push(8'h1);  chk("latch_brew", 8'(brew_inhibit));
    push(8'h0);  chk("latch_code_idle", 8'(code));
    tick();
    push(8'h2);  chk("show_code_010", 8'(code));

    // Fault goes away: mask holds without ack, clears on ack, then back to OK
    sensor = 5'b0;
    for (int i = 0; i < DEB + 3; i++) tick();
    push(8'h02); chk("hold_no_ack", 8'(err_mask));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push(8'h00); chk("ack_clear_mask", 8'(err_mask));
    push(8'h0);  chk("ack_clear_any", 8'(err_any));
    tick();
    push(8'h0);  chk("ack_idle_code", 8'(code));
    push(8'h0);  chk("ack_idle_brew", 8'(brew_inhibit));

    // Glitch shorter than the debounce window is ignored
    sensor = 5'b00001;
    for (int i = 0; i < 3; i++) tick();
    sensor = 5'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      push(8'h00); chk("glitch_mask", 8'(err_mask));
    end
    push(8'h0); chk("glitch_code", 8'(code));

    // Two faults: round-robin 001/101 every DWELL cycles; ack while held changes nothing
    sensor = 5'b10001;
    for (int i = 0; i < DEB + 3; i++) tick();
    push(8'h11); chk("two_mask", 8'(err_mask));
    tick();
    for (int j = 0; j < 3 * DWELL; j++) begin
      push(((j / DWELL) % 2 == 1) ? 8'h5 : 8'h1);
      chk("rr_code", 8'(code));
      ack = (j >= 3 && j <= 5);
      if (j < 3 * DWELL - 1) tick();
    end
    ack = 1'b0;
    push(8'h11); chk("rr_mask_after_ack", 8'(err_mask));
    pos = 3 * DWELL - 1;

    // Drop the heater fault; after it filters low, ack while 101 is still on the digit
    sensor = 5'b00001;
    for (int i = 0; i < DEB + 3; i++) tick();
    pos = pos + DEB + 3;
    push(((pos / DWELL) % 2 == 1) ? 8'h5 : 8'h1); chk("drop4_code_before", 8'(code));
    push(8'h11); chk("drop4_mask_no_ack", 8'(err_mask));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push(8'h01); chk("drop4_mask", 8'(err_mask));
    push(8'h5);  chk("drop4_code_hold", 8'(code));
    tick();
    push(8'h1);  chk("drop4_code_next", 8'(code));

    // Drop the last fault with ack held high: clears the cycle after it filters low
    sensor = 5'b0;
    ack    = 1'b1;
    for (int i = 0; i < DEB + 2; i++) tick();
    push(8'h01); chk("drop0_mask_before", 8'(err_mask));
    tick();
    push(8'h00); chk("drop0_mask", 8'(err_mask));
    push(8'h0);  chk("drop0_err_any", 8'(err_any));
    tick();
    push(8'h0);  chk("drop0_code", 8'(code));
    push(8'h0);  chk("drop0_brew", 8'(brew_inhibit));
    ack = 1'b0;

    // Reset while showing a fault discards it and restarts the lamp test
    sensor = 5'b00100;
    for (int i = 0; i < DEB + 3; i++) tick();
    tick();
    push(8'h3);  chk("pre_rst_code", 8'(code));
    reset = 1'b1;
    tick();
    push(8'h7);  chk("mid_rst_code", 8'(code));
    push(8'h00); chk("mid_rst_mask", 8'(err_mask));
    push(8'h1);  chk("mid_rst_brew", 8'(brew_inhibit));

    // After reset, with ack held, the still-present fault latches during lamp test
    reset = 1'b0;
    ack   = 1'b1;
    for (int i = 0; i < DEB + 3; i++) tick();
    push(8'h04); chk("ackset_mask", 8'(err_mask));
    push(8'h7);  chk("ackset_code_test", 8'(code));
    tick();
    push(8'h0);  chk("ackset_code_idle", 8'(code));
    tick();
    push(8'h3);  chk("ackset_code_show", 8'(code));
    push(8'h1);  chk("ackset_brew", 8'(brew_inhibit));
    ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
